// File: rtl/fpga_rst_pkg.sv
// Shared types, cause codes and helpers for the FPGA reset sequencer.
package fpga_rst_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      StWaitLock  = 2'd0,
      StHold      = 2'd1,
      StRelPeriph = 2'd2,
      StRun       = 2'd3
   } seq_state_e;

   // Reset cause codes reported on rst_cause_o
   localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
   localparam logic [1:0] RST_CAUSE_LOCK = 2'b01;
   localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;

   // Largest of three values, used to size the shared phase counter
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Increment that sticks at all-ones
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset; output resets to 0.
module rst_sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;

   // Shift the asynchronous input through two flops
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

// File: rtl/fpga_rst_seq.sv
// FPGA reset sequencer: qualifies PLL lock, holds resets, then releases
// peripheral reset followed by SoC reset. Records the cause of re-entry.
module fpga_rst_seq
   import fpga_rst_pkg::*;
#(
   parameter int unsigned LOCK_FILTER = 1024,
   parameter int unsigned HOLD_CYCLES = 4096,
   parameter int unsigned GAP_CYCLES  = 256
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       pll_locked_i,
   input  logic       soft_rst_i,
   output logic       periph_rst_n_o,
   output logic       soc_rst_n_o,
   output logic       ready_o,
   output logic [1:0] rst_cause_o,
   output logic [7:0] rst_cnt_o
);

   localparam int unsigned CNT_MAX = max3(LOCK_FILTER, HOLD_CYCLES, GAP_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cause_d;
   logic [7:0]       rcnt_d;
   logic             periph_d, soc_d;
   logic             lock_s;

   rst_sync_2ff u_lock_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (pll_locked_i),
      .q_o     (lock_s)
   );

   // Next-state, counter and cause/count decode; lock loss overrides everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      cause_d = rst_cause_o;
      rcnt_d  = rst_cnt_o;

      unique case (state_q)
         StWaitLock: begin
            if (!lock_s) begin
               cnt_d = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = StHold;
               cnt_d   = '0;
            end
         end
         StHold: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = StRelPeriph;
               cnt_d   = '0;
            end
         end
         StRelPeriph: begin
            if (cnt_q == GAP_LAST) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            // Counter idles at zero while running
            cnt_d = '0;
            if (soft_rst_i) begin
               state_d = StHold;
               cause_d = RST_CAUSE_SOFT;
               rcnt_d  = sat_inc8(rst_cnt_o);
            end
         end
         default: begin
            state_d = StWaitLock;
            cnt_d   = '0;
         end
      endcase

      if (state_q != StWaitLock && !lock_s) begin
         state_d = StWaitLock;
         cnt_d   = '0;
         cause_d = RST_CAUSE_LOCK;
         rcnt_d  = sat_inc8(rst_cnt_o);
      end

      periph_d = (state_d == StRelPeriph) || (state_d == StRun);
      soc_d    = (state_d == StRun);
   end

   // State, counter and registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= StWaitLock;
         cnt_q          <= '0;
         periph_rst_n_o <= 1'b0;
         soc_rst_n_o    <= 1'b0;
         ready_o        <= 1'b0;
         rst_cause_o    <= RST_CAUSE_POR;
         rst_cnt_o      <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         periph_rst_n_o <= periph_d;
         soc_rst_n_o    <= soc_d;
         ready_o        <= soc_d;
         rst_cause_o    <= cause_d;
         rst_cnt_o      <= rcnt_d;
      end
   end

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Self-checking bench for fpga_rst_seq: directed scenarios plus random lock/soft
// activity, all compared against a timestamp-based reference model.
module tb_fpga_rst_seq;

   localparam int LF = 4;
   localparam int HC = 8;
   localparam int GC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst;
   logic       periph_rst_n;
   logic       soc_rst_n;
   logic       ready;
   logic [1:0] rst_cause;
   logic [7:0] rst_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: lock sampling pipe, streak of qualified highs, and the
   // edge at which the current hold phase started (-1 when waiting for lock).
   bit m_s1, m_s2;
   int m_streak;
   int m_hold_at;
   int m_cause;
   int m_cnt;
   int edge_n = 0;

   fpga_rst_seq #(
      .LOCK_FILTER (LF),
      .HOLD_CYCLES (HC),
      .GAP_CYCLES  (GC)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .pll_locked_i   (pll_locked),
      .soft_rst_i     (soft_rst),
      .periph_rst_n_o (periph_rst_n),
      .soc_rst_n_o    (soc_rst_n),
      .ready_o        (ready),
      .rst_cause_o    (rst_cause),
      .rst_cnt_o      (rst_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
      end
   endtask

   function automatic int m_periph();
      return (m_hold_at >= 0 && (edge_n - m_hold_at) >= HC) ? 1 : 0;
   endfunction

   function automatic int m_soc();
      return (m_hold_at >= 0 && (edge_n - m_hold_at) >= HC + GC) ? 1 : 0;
   endfunction

   function automatic int exp_pack();
      return (m_periph() << 12) | (m_soc() << 11) | (m_soc() << 10) | (m_cause << 8) | m_cnt;
   endfunction

   function automatic int dut_pack();
      return int'({periph_rst_n, soc_rst_n, ready, rst_cause, rst_cnt});
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_streak = 0; m_hold_at = -1; m_cause = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      bit ls;
      bit was_run;
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      was_run = (m_hold_at >= 0) && ((edge_n - 1 - m_hold_at) >= HC + GC);
      if (m_hold_at < 0) begin
         m_streak = ls ? m_streak + 1 : 0;
         if (m_streak == LF) begin
            m_hold_at = edge_n;
            m_streak  = 0;
         end
      end else if (!ls) begin
         m_hold_at = -1;
         m_streak  = 0;
         m_cause   = 1;
         m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (soft_rst && was_run) begin
         m_hold_at = edge_n;
         m_cause   = 2;
         m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
   endtask

   // One clock: model advances on the edge, DUT compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      edge_n++;
      model_step();
      @(negedge clk);
      check_eq("outs", dut_pack(), exp_pack());
   endtask

   task automatic wait_run();
      int k;
      k = 0;
      while (m_soc() == 0 && k < 200) begin
         cycle();
         k++;
      end
      check_eq("wait_run_ready", int'(ready), 1);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_outs", dut_pack(), 0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int base;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      soft_rst   = 1'b0;
      model_reset();
      #1;
      check_eq("por_outs", dut_pack(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cold boot: edge 0 is the last edge with lock low
      cycle();
      base = edge_n;
      pll_locked = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         cycle();
         if (k == 13) check_eq("boot_periph_e13", int'(periph_rst_n), 0);
         if (k == 14) check_eq("boot_periph_e14", int'(periph_rst_n), 1);
         if (k == 17) check_eq("boot_soc_e17", int'(soc_rst_n), 0);
         if (k == 18) check_eq("boot_soc_e18", int'({soc_rst_n, ready, rst_cause, rst_cnt}),
                               int'({1'b1, 1'b1, 2'b00, 8'd0}));
      end

      // Lock loss in RUN for 5 cycles
      pll_locked = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cycle();
         if (k == 2) check_eq("loss_still_up", int'({periph_rst_n, soc_rst_n}), 3);
         if (k == 3) check_eq("loss_down", int'({periph_rst_n, soc_rst_n, ready, rst_cause,
                                                  rst_cnt}), int'({3'b000, 2'b01, 8'd1}));
      end
      pll_locked = 1'b1;
      wait_run();

      // Soft reset in RUN, plus an ignored pulse during HOLD
      soft_rst = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         cycle();
         soft_rst = (k == 3);
         if (k == 1) check_eq("soft_down", int'({periph_rst_n, soc_rst_n, rst_cause, rst_cnt}),
                              int'({2'b00, 2'b10, 8'd2}));
         if (k == 8) check_eq("soft_periph_s8", int'(periph_rst_n), 0);
         if (k == 9) check_eq("soft_periph_s9", int'(periph_rst_n), 1);
         if (k == 12) check_eq("soft_soc_s12", int'(soc_rst_n), 0);
         if (k == 13) check_eq("soft_soc_s13", int'({soc_rst_n, ready}), 3);
      end

      // Lock loss and soft request seen in the same RUN cycle
      pll_locked = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         cycle();
         soft_rst = (k == 2);
         if (k == 3) check_eq("simul_cause", int'({periph_rst_n, soc_rst_n, ready, rst_cause,
                                                    rst_cnt}), int'({3'b000, 2'b01, 8'd3}));
      end
      soft_rst = 1'b0;
      pll_locked = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (k == 13) check_eq("simul_relock_e13", int'(periph_rst_n), 0);
         if (k == 14) check_eq("simul_relock_e14", int'(periph_rst_n), 1);
      end
      wait_run();

      // Async reset in the middle of HOLD
      soft_rst = 1'b1;
      cycle();
      soft_rst = 1'b0;
      cycle();
      cycle();
      pll_locked = 1'b0;
      async_reset();
      check_eq("async_cnt_clear", int'(rst_cnt), 0);

      // Glitch during lock filtering restarts the filter
      cycle();
      pll_locked = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      pll_locked = 1'b0;
      cycle();
      pll_locked = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         cycle();
         if (k == 13) check_eq("glitch_periph_e13", int'(periph_rst_n), 0);
         if (k == 14) check_eq("glitch_periph_e14", int'(periph_rst_n), 1);
      end

      // 300 lock-loss events drive the reset count into saturation
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         for (int k = 0; k < 4; k++) cycle();
         pll_locked = 1'b1;
         for (int k = 0; k < 7; k++) cycle();
      end
      check_eq("cnt_saturated", int'(rst_cnt), 255);

      // Random lock flaps and soft requests
      async_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) pll_locked = ~pll_locked;
         soft_rst = ($urandom_range(0, 24) == 0);
         cycle();
      end
      soft_rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
